wb_arbiter: RTL and testbench

Writeback arbiter and write initiator for the physical register file. It accepts completed results (physical destination register plus 32-bit data) from the ALU, LSU and branch units through per-unit valid/ready queues. It round-robin arbitrates among them and drives at most one registered write per cycle into the physical register file's single write port. That write also sets the destination ready in the ready table.

---
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs, round-robin grant, one registered PRF write per cycle.
// Define WB_BYPASS_EN to let an empty unit's same-cycle handshake compete for the grant directly.
module wb_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [PREG_W-1:0] alu_wb_preg,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [PREG_W-1:0] lsu_wb_preg,
  input  logic [DATA_W-1:0] lsu_wb_data,
  input  logic              br_wb_valid,
  output logic              br_wb_ready,
  input  logic [PREG_W-1:0] br_wb_preg,
  input  logic [DATA_W-1:0] br_wb_data,
  output logic              prf_write,
  output logic [PREG_W-1:0] prf_target_reg,
  output logic [DATA_W-1:0] prf_write_data,
  output logic [1:0]        prf_src
);
  localparam int unsigned NumUnits = 3;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned EntW     = PREG_W + DATA_W;

  logic [EntW-1:0] mem_q    [NumUnits][DEPTH];
  logic [PtrW-1:0] rd_ptr_q [NumUnits];
  logic [PtrW-1:0] wr_ptr_q [NumUnits];
  logic [CntW-1:0] cnt_q    [NumUnits];
  logic [1:0]      rr_q;

  logic [NumUnits-1:0] in_valid;
  logic [NumUnits-1:0] ready;
  logic [NumUnits-1:0] nonempty;
  logic [NumUnits-1:0] cand;
  logic [NumUnits-1:0] gnt_oh;
  logic [NumUnits-1:0] push;
  logic [NumUnits-1:0] pop;
  logic [EntW-1:0]     in_entry [NumUnits];
  logic [EntW-1:0]     gnt_entry;
  logic                grant;
  logic [1:0]          gnt_idx;
  logic [1:0]          rr_d;
  logic [1:0]          sel;

  always_comb begin
    in_valid    = {br_wb_valid, lsu_wb_valid, alu_wb_valid};
    in_entry[0] = {alu_wb_preg, alu_wb_data};
    in_entry[1] = {lsu_wb_preg, lsu_wb_data};
    in_entry[2] = {br_wb_preg, br_wb_data};

    for (int i = 0; i < NumUnits; i++) begin
      ready[i]    = cnt_q[i] < CntW'(DEPTH);
      nonempty[i] = cnt_q[i] != '0;
`ifdef WB_BYPASS_EN
      // An empty queue offers its live input; ready is guaranteed high when empty.
      cand[i] = !flush && (nonempty[i] || in_valid[i]);
`else
      cand[i] = !flush && nonempty[i];
`endif
    end

    grant   = 1'b0;
    gnt_idx = 2'd0;
    gnt_oh  = '0;
    sel     = 2'd0;
    for (int k = 0; k < NumUnits; k++) begin
      sel = 2'((32'(rr_q) + 32'(k)) % NumUnits);
      if (!grant && cand[sel]) begin
        grant       = 1'b1;
        gnt_idx     = sel;
        gnt_oh[sel] = 1'b1;
      end
    end

    gnt_entry = '0;
    for (int i = 0; i < NumUnits; i++) begin
      pop[i]  = gnt_oh[i] && nonempty[i];
      // A granted bypass result goes straight to the output and is not queued.
      push[i] = in_valid[i] && ready[i] && !flush && !(gnt_oh[i] && !nonempty[i]);
      if (gnt_oh[i]) begin
        gnt_entry = nonempty[i] ? mem_q[i][rd_ptr_q[i]] : in_entry[i];
      end
    end

    rr_d = rr_q;
    if (grant) begin
      rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  assign alu_wb_ready = ready[0];
  assign lsu_wb_ready = ready[1];
  assign br_wb_ready  = ready[2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumUnits; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_entry[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumUnits; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rr_q           <= 2'd0;
      prf_write      <= 1'b0;
      prf_target_reg <= '0;
      prf_write_data <= '0;
      prf_src        <= 2'd0;
    end else if (flush) begin
      for (int i = 0; i < NumUnits; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rr_q      <= 2'd0;
      prf_write <= 1'b0;
    end else begin
      for (int i = 0; i < NumUnits; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
        cnt_q[i] <= cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      rr_q      <= rr_d;
      prf_write <= grant;
      if (grant) begin
        prf_target_reg <= gnt_entry[EntW-1:DATA_W];
        prf_write_data <= gnt_entry[DATA_W-1:0];
        prf_src        <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-unit expected queues filled at handshake, drained on writes.
module tb_wb_arbiter;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EntW   = PREG_W + DATA_W;
`ifdef WB_BYPASS_EN
  localparam int unsigned Lat = 0;
`else
  localparam int unsigned Lat = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              alu_wb_valid, lsu_wb_valid, br_wb_valid;
  logic              alu_wb_ready, lsu_wb_ready, br_wb_ready;
  logic [PREG_W-1:0] alu_wb_preg, lsu_wb_preg, br_wb_preg;
  logic [DATA_W-1:0] alu_wb_data, lsu_wb_data, br_wb_data;
  logic              prf_write;
  logic [PREG_W-1:0] prf_target_reg;
  logic [DATA_W-1:0] prf_write_data;
  logic [1:0]        prf_src;

  wb_arbiter #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_preg(alu_wb_preg), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_preg(lsu_wb_preg), .lsu_wb_data(lsu_wb_data),
    .br_wb_valid(br_wb_valid), .br_wb_ready(br_wb_ready),
    .br_wb_preg(br_wb_preg), .br_wb_data(br_wb_data),
    .prf_write(prf_write), .prf_target_reg(prf_target_reg),
    .prf_write_data(prf_write_data), .prf_src(prf_src)
  );

  always #5 clk = ~clk;

  logic [EntW-1:0]   offer_q [3][$];
  logic [EntW-1:0]   exp_q   [3][$];
  logic [PREG_W-1:0] log_preg [$];
  int unsigned       log_edge [$];
  logic [1:0]        log_src [$];
  int unsigned       hs_edge [3];
  int unsigned       wr_edge_last [3];
  int unsigned       cyc = 0;
  bit                drv_en = 1'b0;
  bit                saw_br_block = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                base;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 3; i++) n += offer_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < 3; i++) begin
      offer_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0; alu_wb_preg = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_preg = '0; lsu_wb_data = '0;
    br_wb_valid  = 1'b0; br_wb_preg  = '0; br_wb_data  = '0;
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input int u, input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d);
    offer_q[u].push_back({p, d});
  endtask

  task automatic do_reset();
    drv_en = 1'b0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_queues();
    drv_en = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("idle_timeout", 64'(pending()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Producer model: offers the head of each unit's offer queue; handshake when ready is high.
  initial begin
    logic [2:0]      drv_v, drv_rdy;
    logic [EntW-1:0] drv_e [3];
    forever begin
      @(negedge clk);
      if (drv_en && !reset) begin
        drv_rdy = {br_wb_ready, lsu_wb_ready, alu_wb_ready};
        for (int i = 0; i < 3; i++) begin
          drv_v[i] = 1'b0;
          drv_e[i] = '0;
          if (offer_q[i].size() > 0) begin
            drv_v[i] = 1'b1;
            drv_e[i] = offer_q[i][0];
            if (i == 2 && !drv_rdy[i]) saw_br_block = 1'b1;
            if (drv_rdy[i]) begin
              if (!flush) begin
                exp_q[i].push_back(drv_e[i]);
                hs_edge[i] = cyc + 1;
              end
              void'(offer_q[i].pop_front());
            end
          end
        end
        alu_wb_valid = drv_v[0]; {alu_wb_preg, alu_wb_data} = drv_e[0];
        lsu_wb_valid = drv_v[1]; {lsu_wb_preg, lsu_wb_data} = drv_e[1];
        br_wb_valid  = drv_v[2]; {br_wb_preg,  br_wb_data}  = drv_e[2];
      end
    end
  end

  initial begin
    logic [EntW-1:0] got, e;
    int s;
    forever begin
      @(negedge clk);
      if (prf_write) begin
        s   = int'(prf_src);
        got = {prf_target_reg, prf_write_data};
        log_preg.push_back(prf_target_reg);
        log_edge.push_back(cyc);
        log_src.push_back(prf_src);
        if (s > 2) begin
          check_eq("src_range", 64'(prf_src), 64'd2);
        end else if (exp_q[s].size() == 0) begin
          check_eq("unexpected_write", 64'(prf_write), 64'd0);
        end else begin
          e = exp_q[s].pop_front();
          check_eq("wb_entry", 64'(got), 64'(e));
          wr_edge_last[s] = cyc;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle_inputs();
    #3;
    check_eq("rst_write", 64'(prf_write), 64'd0);
    check_eq("rst_target", 64'(prf_target_reg), 64'd0);
    check_eq("rst_data", 64'(prf_write_data), 64'd0);
    check_eq("rst_src", 64'(prf_src), 64'd0);
    check_eq("rst_ready", 64'({alu_wb_ready, lsu_wb_ready, br_wb_ready}), 64'(3'b111));
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    drv_en = 1'b1;

    // Single ALU result: latency and exactly one write.
    sync();
    base = log_preg.size();
    offer(0, 7'd5, 32'hDEADBEEF);
    wait_idle();
    check_eq("single_count", 64'(log_preg.size() - base), 64'd1);
    if (log_preg.size() > base) begin
      check_eq("single_latency", 64'(log_edge[base] - hs_edge[0]), 64'(Lat));
      check_eq("single_src", 64'(log_src[base]), 64'd0);
    end

    // Three units at once from rr=ALU: consecutive writes 10, 11, 12.
    do_reset();
    sync();
    base = log_preg.size();
    offer(0, 7'd10, 32'h0A0A_0001);
    offer(1, 7'd11, 32'h0B0B_0002);
    offer(2, 7'd12, 32'h0C0C_0003);
    wait_idle();
    check_eq("rr3_count", 64'(log_preg.size() - base), 64'd3);
    if (log_preg.size() >= base + 3) begin
      for (int k = 0; k < 3; k++) check_eq("rr3_order", 64'(log_preg[base+k]), 64'(10 + k));
      for (int k = 1; k < 3; k++)
        check_eq("rr3_back_to_back", 64'(log_edge[base+k] - log_edge[base+k-1]), 64'd1);
    end
    // rr must be back at ALU: ALU beats BR.
    sync();
    base = log_preg.size();
    offer(2, 7'd22, 32'h2222_2222);
    offer(0, 7'd20, 32'h2020_2020);
    wait_idle();
    if (log_preg.size() >= base + 2) begin
      check_eq("rr_end_first", 64'(log_preg[base]), 64'd20);
      check_eq("rr_end_second", 64'(log_preg[base+1]), 64'd22);
    end else begin
      check_eq("rr_end_count", 64'(log_preg.size() - base), 64'd2);
    end

    // ALU streams; LSU joins once the ALU queue is busy and must not starve.
    sync();
    for (int k = 1; k <= 8; k++) offer(0, 7'(k), 32'h100 + 32'(k));
    repeat (2) sync();
    offer(1, 7'd40, 32'h4040_4040);
    wait_idle();
    check_eq("lsu_starve", 64'((wr_edge_last[1] - hs_edge[1]) <= 3), 64'd1);

    // All units stream; BR queue fills and back-pressures without loss or duplication.
    saw_br_block = 1'b0;
    sync();
    base = log_preg.size();
    for (int k = 0; k < 6; k++) begin
      offer(0, 7'(60 + k), $urandom);
      offer(1, 7'(70 + k), $urandom);
      offer(2, 7'(80 + k), $urandom);
    end
    wait_idle();
    check_eq("br_backpressure", 64'(saw_br_block), 64'd1);
    check_eq("stream_count", 64'(log_preg.size() - base), 64'd18);

    // Flush with ALU/LSU entries queued and a BR result offered.
    do_reset();
    sync();
    offer(0, 7'd90, 32'h9090_0000);
    offer(0, 7'd91, 32'h9191_0000);
    offer(1, 7'd92, 32'h9292_0000);
    sync();
    sync();
    flush = 1'b1;
    offer(2, 7'd93, 32'h9393_0000);
    sync();
    flush = 1'b0;
    clear_queues();
    @(negedge clk);
    check_eq("flush_no_write", 64'(prf_write), 64'd0);
    check_eq("flush_ready", 64'({alu_wb_ready, lsu_wb_ready, br_wb_ready}), 64'(3'b111));
    sync();
    base = log_preg.size();
    offer(0, 7'd95, 32'h9595_9595);
    wait_idle();
    check_eq("post_flush_count", 64'(log_preg.size() - base), 64'd1);
    if (log_preg.size() > base)
      check_eq("post_flush_latency", 64'(log_edge[base] - hs_edge[0]), 64'(Lat));

    // Asynchronous reset mid-stream.
    sync();
    for (int k = 0; k < 6; k++) begin
      offer(0, 7'(100 + k), $urandom);
      offer(1, 7'(110 + k), $urandom);
    end
    repeat (3) sync();
    reset  = 1'b1;
    drv_en = 1'b0;
    #1;
    check_eq("async_rst_write", 64'(prf_write), 64'd0);
    check_eq("async_rst_target", 64'(prf_target_reg), 64'd0);
    idle_inputs();
    clear_queues();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    base   = log_preg.size();
    drv_en = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("no_stale_write", 64'(log_preg.size() - base), 64'd0);
    check_eq("post_rst_ready", 64'({alu_wb_ready, lsu_wb_ready, br_wb_ready}), 64'(3'b111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
